avl_burst_master: RTL and testbench



---
 rtl/avl_burst_master.sv | 232 +++++++++++++++++++++++
 tb/tb_avl_burst_master.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avl_burst_master.sv
// avl_burst_master: Avalon-MM master bridge for the core's native memory port.
// Issues single-beat data reads/writes and fixed-length instruction burst reads.
// Optional feature macro: AVL_RESP_ERROR_EN (slave response errors, write responses).
module avl_burst_master #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BURST_LEN  = 4
) (
    input  logic                                                    clock,
    input  logic                                                    reset,
    input  logic                                                    avl_valid,
    input  logic                                                    avl_instr,
    input  logic [ADDR_WIDTH-1:0]                                   avl_addr,
    input  logic [DATA_WIDTH-1:0]                                   avl_wdata,
    input  logic [DATA_WIDTH/8-1:0]                                 avl_wstrb,
    output logic [DATA_WIDTH-1:0]                                   avl_rdata,
    output logic                                                    avl_rvalid,
    output logic [((BURST_LEN > 1) ? $clog2(BURST_LEN) : 1)-1:0]    avl_beat,
    output logic                                                    avl_ready,
    output logic                                                    avl_error,
    output logic [ADDR_WIDTH-1:0]                                   m_avl_address,
    output logic [DATA_WIDTH/8-1:0]                                 m_avl_byteenable,
    output logic                                                    m_avl_lock,
    output logic                                                    m_avl_read,
    output logic [DATA_WIDTH-1:0]                                   m_avl_writedata,
    output logic                                                    m_avl_write,
    output logic [$clog2(BURST_LEN):0]                              m_avl_burstcount,
    input  logic [DATA_WIDTH-1:0]                                   m_avl_readdata,
    input  logic [1:0]                                              m_avl_response,
    input  logic                                                    m_avl_waitrequest,
    input  logic                                                    m_avl_readdatavalid,
    input  logic                                                    m_avl_writeresponsevalid
);

    localparam int unsigned BYTES    = DATA_WIDTH / 8;
    localparam int unsigned BEAT_W   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int unsigned BCW      = $clog2(BURST_LEN) + 1;
    localparam int unsigned WORD_OFS = $clog2(BYTES);
    localparam int unsigned LINE_OFS = $clog2(BURST_LEN * BYTES);

    localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~((ADDR_WIDTH'(1) << WORD_OFS) - ADDR_WIDTH'(1));
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~((ADDR_WIDTH'(1) << LINE_OFS) - ADDR_WIDTH'(1));

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]            state_q,  state_d;
    logic [ADDR_WIDTH-1:0] addr_q,   addr_d;
    logic [BYTES-1:0]      be_q,     be_d;
    logic [DATA_WIDTH-1:0] wdata_q,  wdata_d;
    logic [BCW-1:0]        burst_q,  burst_d;
    logic                  read_q,   read_d;
    logic                  write_q,  write_d;
    logic [BCW-1:0]        cnt_q,    cnt_d;
    logic [DATA_WIDTH-1:0] rdata_q,  rdata_d;
    logic                  rvalid_q, rvalid_d;
    logic [BEAT_W-1:0]     beat_q,   beat_d;
    logic                  ready_q,  ready_d;
    logic                  error_q,  error_d;
    logic                  cmd_accept;
`ifdef AVL_RESP_ERROR_EN
    logic                  err_q,    err_d;
    logic                  wpend_q,  wpend_d;
`else
    logic                  unused_resp;
    assign unused_resp = ^{m_avl_response, m_avl_writeresponsevalid};
`endif

    // Command handshake completes when a strobe is up and the slave is not stalling
    assign cmd_accept = (read_q | write_q) & ~m_avl_waitrequest;

    // Next-state and output decode
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        burst_d  = burst_q;
        read_d   = read_q;
        write_d  = write_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        beat_d   = beat_q;
        ready_d  = 1'b0;
        error_d  = 1'b0;
`ifdef AVL_RESP_ERROR_EN
        err_d    = err_q;
        wpend_d  = wpend_q;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
`ifdef AVL_RESP_ERROR_EN
                err_d   = 1'b0;
                wpend_d = 1'b0;
`endif
                if (avl_valid) begin
                    wdata_d = avl_wdata;
                    if (avl_wstrb != '0) begin
                        addr_d  = avl_addr & WORD_MASK;
                        be_d    = avl_wstrb;
                        burst_d = BCW'(1);
                        write_d = 1'b1;
                        state_d = S_WR;
                    end else if (avl_instr) begin
                        addr_d  = avl_addr & LINE_MASK;
                        be_d    = '1;
                        burst_d = BCW'(BURST_LEN);
                        read_d  = 1'b1;
                        state_d = S_RD;
                    end else begin
                        addr_d  = avl_addr & WORD_MASK;
                        be_d    = '1;
                        burst_d = BCW'(1);
                        read_d  = 1'b1;
                        state_d = S_RD;
                    end
                end
            end
            S_RD: begin
                if (cmd_accept) begin
                    read_d = 1'b0;
                end
                if (m_avl_readdatavalid) begin
                    rvalid_d = 1'b1;
                    rdata_d  = m_avl_readdata;
                    beat_d   = cnt_q[BEAT_W-1:0];
`ifdef AVL_RESP_ERROR_EN
                    if (m_avl_response != 2'b00) begin
                        err_d = 1'b1;
                    end
`endif
                    if (cnt_q == burst_q - BCW'(1)) begin
                        cnt_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + BCW'(1);
                    end
                end
            end
            S_WR: begin
`ifdef AVL_RESP_ERROR_EN
                if (cmd_accept) begin
                    write_d = 1'b0;
                    wpend_d = 1'b1;
                end
                if (m_avl_writeresponsevalid && (wpend_q || cmd_accept)) begin
                    if (m_avl_response != 2'b00) begin
                        err_d = 1'b1;
                    end
                    wpend_d = 1'b0;
                    state_d = S_DONE;
                end
`else
                if (cmd_accept) begin
                    write_d = 1'b0;
                    state_d = S_DONE;
                end
`endif
            end
            S_DONE: begin
                ready_d = 1'b1;
`ifdef AVL_RESP_ERROR_EN
                error_d = err_q;
                err_d   = 1'b0;
`endif
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers, synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
            burst_q  <= '0;
            read_q   <= 1'b0;
            write_q  <= 1'b0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            beat_q   <= '0;
            ready_q  <= 1'b0;
            error_q  <= 1'b0;
`ifdef AVL_RESP_ERROR_EN
            err_q    <= 1'b0;
            wpend_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            burst_q  <= burst_d;
            read_q   <= read_d;
            write_q  <= write_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            beat_q   <= beat_d;
            ready_q  <= ready_d;
            error_q  <= error_d;
`ifdef AVL_RESP_ERROR_EN
            err_q    <= err_d;
            wpend_q  <= wpend_d;
`endif
        end
    end

    assign avl_rdata        = rdata_q;
    assign avl_rvalid       = rvalid_q;
    assign avl_beat         = beat_q;
    assign avl_ready        = ready_q;
    assign avl_error        = error_q;
    assign m_avl_address    = addr_q;
    assign m_avl_byteenable = be_q;
    assign m_avl_lock       = 1'b0;
    assign m_avl_read       = read_q;
    assign m_avl_writedata  = wdata_q;
    assign m_avl_write      = write_q;
    assign m_avl_burstcount = burst_q;

endmodule

// File: tb/tb_avl_burst_master.sv
// tb_avl_burst_master: scoreboard bench for avl_burst_master (default parameters).
module tb_avl_burst_master;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned BL = 4;
`ifdef AVL_RESP_ERROR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct packed {
        logic [DW-1:0] data;
        logic [1:0]    beat;
    } beat_t;

    logic          clock = 1'b0;
    logic          reset;
    logic          avl_valid, avl_instr;
    logic [AW-1:0] avl_addr;
    logic [DW-1:0] avl_wdata;
    logic [3:0]    avl_wstrb;
    logic [DW-1:0] avl_rdata;
    logic          avl_rvalid;
    logic [1:0]    avl_beat;
    logic          avl_ready, avl_error;
    logic [AW-1:0] m_avl_address;
    logic [3:0]    m_avl_byteenable;
    logic          m_avl_lock, m_avl_read, m_avl_write;
    logic [DW-1:0] m_avl_writedata;
    logic [2:0]    m_avl_burstcount;
    logic [DW-1:0] m_avl_readdata;
    logic [1:0]    m_avl_response;
    logic          m_avl_waitrequest, m_avl_readdatavalid, m_avl_writeresponsevalid;

    avl_burst_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
        .clock(clock), .reset(reset),
        .avl_valid(avl_valid), .avl_instr(avl_instr), .avl_addr(avl_addr),
        .avl_wdata(avl_wdata), .avl_wstrb(avl_wstrb),
        .avl_rdata(avl_rdata), .avl_rvalid(avl_rvalid), .avl_beat(avl_beat),
        .avl_ready(avl_ready), .avl_error(avl_error),
        .m_avl_address(m_avl_address), .m_avl_byteenable(m_avl_byteenable),
        .m_avl_lock(m_avl_lock), .m_avl_read(m_avl_read),
        .m_avl_writedata(m_avl_writedata), .m_avl_write(m_avl_write),
        .m_avl_burstcount(m_avl_burstcount), .m_avl_readdata(m_avl_readdata),
        .m_avl_response(m_avl_response), .m_avl_waitrequest(m_avl_waitrequest),
        .m_avl_readdatavalid(m_avl_readdatavalid),
        .m_avl_writeresponsevalid(m_avl_writeresponsevalid)
    );

    always #5 clock = ~clock;

    int    vecs = 0;
    int    errs = 0;
    int    cyc = 0;
    int    ready_cyc = -1;
    int    rvalid_cyc = -1;
    int    n_acc = 0;
    int    n_ready = 0;
    beat_t rd_q[$];
    logic  ry_q[$];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expected beats / completions whenever the DUT presents them
    always @(negedge clock) begin : mon
        beat_t e;
        logic  ee;
        if (avl_rvalid) begin
            rvalid_cyc = cyc;
            if (rd_q.size() == 0) begin
                vecs++;
                errs++;
                $display("FAIL rvalid_unexpected: got beat %0d data 0x%0h expected no beat (cycle %0d)",
                         avl_beat, avl_rdata, cyc);
            end else begin
                e = rd_q.pop_front();
                check("rdata", 64'(avl_rdata), 64'(e.data));
                check("beat", 64'(avl_beat), 64'(e.beat));
            end
        end
        if (avl_ready) begin
            ready_cyc = cyc;
            n_ready++;
            if (ry_q.size() == 0) begin
                vecs++;
                errs++;
                $display("FAIL ready_unexpected: got avl_ready=1 expected 0 (cycle %0d)", cyc);
            end else begin
                ee = ry_q.pop_front();
                check("error", 64'(avl_error), 64'(ee));
            end
        end
        if ((m_avl_read || m_avl_write) && !m_avl_waitrequest) n_acc++;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic exp_beat(input logic [DW-1:0] d, input logic [1:0] b);
        rd_q.push_back(beat_t'{data: d, beat: b});
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_strobes"}, 64'({m_avl_read, m_avl_write, m_avl_lock, avl_rvalid, avl_ready, avl_error}), 64'(0));
        check({tag, "_addr"}, 64'(m_avl_address), 64'(0));
        check({tag, "_be_bc_beat"}, 64'({m_avl_byteenable, m_avl_burstcount, avl_beat}), 64'(0));
        check({tag, "_data"}, {m_avl_writedata, avl_rdata}, 64'(0));
    endtask

    task automatic idle_inputs;
        avl_valid = 1'b0; avl_instr = 1'b0; avl_addr = '0; avl_wdata = '0; avl_wstrb = '0;
        m_avl_readdata = '0; m_avl_response = 2'b00; m_avl_waitrequest = 1'b0;
        m_avl_readdatavalid = 1'b0; m_avl_writeresponsevalid = 1'b0;
    endtask

    initial begin : stim
        int n, m, a, acc0, r0;
        int gaps[4];
        gaps = '{1, 0, 2, 1};
        reset = 1'b0;
        idle_inputs();
        repeat (3) tick();
        check_zero("reset");
        reset = 1'b1;
        tick();

        // Single read, unaligned address, zero-wait slave
        acc0 = n_acc; r0 = n_ready;
        avl_valid = 1'b1; avl_instr = 1'b0; avl_addr = 32'h1006; avl_wstrb = 4'h0;
        n = cyc;
        tick();
        avl_valid = 1'b0;
        check("t1_read", 64'(m_avl_read), 64'(1));
        check("t1_write", 64'(m_avl_write), 64'(0));
        check("t1_addr", 64'(m_avl_address), 64'h1004);
        check("t1_be", 64'(m_avl_byteenable), 64'hF);
        check("t1_bc", 64'(m_avl_burstcount), 64'(1));
        tick();
        check("t1_read_drop", 64'(m_avl_read), 64'(0));
        m_avl_readdata = 32'hDEADBEEF; m_avl_readdatavalid = 1'b1;
        exp_beat(32'hDEADBEEF, 2'd0);
        ry_q.push_back(1'b0);
        m = cyc;
        tick();
        m_avl_readdatavalid = 1'b0;
        repeat (4) tick();
        check("t1_rvalid_cyc", 64'(rvalid_cyc), 64'(m + 1));
        check("t1_ready_cyc", 64'(ready_cyc), 64'(n + 4));
        check("t1_ready_cnt", 64'(n_ready - r0), 64'(1));
        check("t1_acc_cnt", 64'(n_acc - acc0), 64'(1));

        // Instruction burst with stalled command, gapped beats, stray request mid-burst
        acc0 = n_acc; r0 = n_ready;
        avl_valid = 1'b1; avl_instr = 1'b1; avl_addr = 32'h2014; avl_wstrb = 4'h0;
        tick();
        avl_valid = 1'b0; avl_instr = 1'b0;
        for (int k = 0; k < 4; k++) begin
            m_avl_waitrequest = (k < 3);
            check("t2_read_hold", 64'(m_avl_read), 64'(1));
            check("t2_addr", 64'(m_avl_address), 64'h2010);
            check("t2_bc", 64'(m_avl_burstcount), 64'(4));
            check("t2_be", 64'(m_avl_byteenable), 64'hF);
            tick();
        end
        m_avl_waitrequest = 1'b0;
        check("t2_read_drop", 64'(m_avl_read), 64'(0));
        m = 0;
        for (int b = 0; b < 4; b++) begin
            repeat (gaps[b]) tick();
            m_avl_readdata = 32'hA0 + 32'(b); m_avl_readdatavalid = 1'b1;
            exp_beat(32'hA0 + 32'(b), 2'(b));
            if (b == 1) begin
                avl_valid = 1'b1; avl_wstrb = 4'hF; avl_addr = 32'h7000;
            end
            if (b == 3) ry_q.push_back(1'b0);
            m = cyc;
            tick();
            m_avl_readdatavalid = 1'b0; avl_valid = 1'b0; avl_wstrb = 4'h0;
        end
        check("t2_last_rvalid", 64'({avl_rvalid, avl_beat, avl_ready}), 64'({1'b1, 2'd3, 1'b0}));
        tick();
        check("t2_ready", 64'(avl_ready), 64'(1));
        tick();
        check("t2_ready_pulse", 64'(avl_ready), 64'(0));
        check("t2_ready_cyc", 64'(ready_cyc), 64'(m + 2));
        check("t2_acc_cnt", 64'(n_acc - acc0), 64'(1));
        check("t2_ready_cnt", 64'(n_ready - r0), 64'(1));

        // Single write with two stall cycles, then a write response five cycles later
        avl_valid = 1'b1; avl_instr = 1'b1; avl_addr = 32'h3000; avl_wstrb = 4'h3;
        avl_wdata = 32'h12345678;
        tick();
        avl_valid = 1'b0; avl_wstrb = 4'h0; avl_instr = 1'b0;
        a = 0;
        for (int k = 0; k < 3; k++) begin
            m_avl_waitrequest = (k < 2);
            check("t3_write_hold", 64'({m_avl_write, m_avl_read}), 64'({1'b1, 1'b0}));
            check("t3_be", 64'(m_avl_byteenable), 64'h3);
            check("t3_wdata", 64'(m_avl_writedata), 64'h12345678);
            check("t3_addr", 64'(m_avl_address), 64'h3000);
            check("t3_bc", 64'(m_avl_burstcount), 64'(1));
            if (k == 2) a = cyc;
            tick();
        end
        m_avl_waitrequest = 1'b0;
        check("t3_write_drop", 64'(m_avl_write), 64'(0));
        ry_q.push_back(ERR_EN);
        repeat (8) begin
            m_avl_writeresponsevalid = (cyc == a + 5);
            m_avl_response = (cyc == a + 5) ? 2'd2 : 2'd0;
            tick();
        end
        m_avl_writeresponsevalid = 1'b0; m_avl_response = 2'd0;
        check("t3_ready_cyc", 64'(ready_cyc), 64'(ERR_EN ? a + 7 : a + 2));

        // Error burst: beat 0 in the acceptance cycle, beat 1 carries a slave error
        avl_valid = 1'b1; avl_instr = 1'b1; avl_addr = 32'h4008; avl_wstrb = 4'h0;
        tick();
        avl_valid = 1'b0; avl_instr = 1'b0;
        check("t4_addr", 64'(m_avl_address), 64'h4000);
        m = 0;
        for (int b = 0; b < 4; b++) begin
            m_avl_readdata = 32'hB0 + 32'(b); m_avl_readdatavalid = 1'b1;
            m_avl_response = (b == 1) ? 2'd2 : 2'd0;
            exp_beat(32'hB0 + 32'(b), 2'(b));
            if (b == 3) ry_q.push_back(ERR_EN);
            m = cyc;
            tick();
        end
        m_avl_readdatavalid = 1'b0; m_avl_response = 2'd0;
        repeat (3) tick();
        check("t4_ready_cyc", 64'(ready_cyc), 64'(m + 2));

        // Reset asserted during beat 2 of a burst; stale beat afterwards is dropped
        avl_valid = 1'b1; avl_instr = 1'b1; avl_addr = 32'h5000;
        tick();
        avl_valid = 1'b0; avl_instr = 1'b0;
        tick();
        for (int b = 0; b < 3; b++) begin
            m_avl_readdata = 32'hC0 + 32'(b); m_avl_readdatavalid = 1'b1;
            if (b < 2) exp_beat(32'hC0 + 32'(b), 2'(b));
            if (b == 2) reset = 1'b0;
            tick();
        end
        reset = 1'b1;
        check_zero("midrst");
        m_avl_readdata = 32'hC3;
        tick();
        m_avl_readdatavalid = 1'b0;
        tick();
        check("t5_idle_after_stale", 64'({avl_rvalid, m_avl_read}), 64'(0));

        // Next request after reset issues normally
        avl_valid = 1'b1; avl_instr = 1'b0; avl_addr = 32'h6003;
        n = cyc;
        tick();
        avl_valid = 1'b0;
        check("t6_addr", 64'(m_avl_address), 64'h6000);
        check("t6_bc", 64'(m_avl_burstcount), 64'(1));
        tick();
        m_avl_readdata = 32'h55AA; m_avl_readdatavalid = 1'b1;
        exp_beat(32'h55AA, 2'd0);
        ry_q.push_back(1'b0);
        tick();
        m_avl_readdatavalid = 1'b0;
        repeat (5) tick();
        check("t6_ready_cyc", 64'(ready_cyc), 64'(n + 4));
        check("rd_q_drained", 64'(rd_q.size()), 64'(0));
        check("ry_q_drained", 64'(ry_q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
